clkrst_seq_gen: RTL

CLKRST_SEQ_GEN -- requirements
Module: clkrst_seq_gen

---
 rtl/clkrst_seq_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/clkrst_seq_gen.sv
// Clock and reset sequence generator. It produces NUM_CH divided clocks with rise strobes,
// and a PRE/ASSERT/WAIT reset sequencer that drives an active-low downstream reset.
module clkrst_seq_gen #(
   parameter int                  NUM_CH      = 2,
   parameter logic [8*NUM_CH-1:0] DIV_HALF    = {8'd2, 8'd1},
   parameter logic [8*NUM_CH-1:0] PHASE       = {8'd0, 8'd0},
   parameter int                  CNT_W       = 16,
   parameter int                  PRE_CYC     = 10,
   parameter int                  ASSERT_CYC  = 100,
   parameter int                  TIMEOUT_CYC = 65535,
   parameter int                  AUTO_START  = 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              seq_start_i,
   input  logic              init_done_i,
   output logic [NUM_CH-1:0] clk_div_o,
   output logic [NUM_CH-1:0] ch_rise_o,
   output logic              sdram_resetn_o,
   output logic              seq_busy_o,
   output logic              seq_done_o,
   output logic              seq_timeout_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRE    = 3'd1,
      S_ASSERT = 3'd2,
      S_WAIT   = 3'd3,
      S_RUN    = 3'd4,
      S_FAIL   = 3'd5
   } state_t;

   // With no PRE window, a (re)start goes straight into ASSERT.
   localparam state_t           L_START    = (PRE_CYC == 0) ? S_ASSERT : S_PRE;
   localparam logic [CNT_W-1:0] L_PRE_LAST = CNT_W'(PRE_CYC - 1);
   localparam logic [CNT_W-1:0] L_AST_LAST = CNT_W'(((ASSERT_CYC == 0) ? 1 : ASSERT_CYC) - 1);
   localparam logic [CNT_W-1:0] L_TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             w_resetn_nxt, w_busy_nxt, w_done_nxt, w_to_nxt;
   logic             r_resetn, r_busy, r_done, r_to;

   // State, counter and registered status outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_resetn <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_to     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_resetn <= w_resetn_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_to     <= w_to_nxt;
      end
   end

   // Next-state and phase counter; init_done_i only matters in WAIT and wins over timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if ((AUTO_START != 0) || seq_start_i) w_state_nxt = L_START;
            else                                  w_state_nxt = S_IDLE;
         end
         S_PRE: begin
            if (r_cnt == L_PRE_LAST) w_state_nxt = S_ASSERT;
            else                     w_state_nxt = S_PRE;
         end
         S_ASSERT: begin
            if (r_cnt == L_AST_LAST) w_state_nxt = S_WAIT;
            else                     w_state_nxt = S_ASSERT;
         end
         S_WAIT: begin
            if (init_done_i)                                   w_state_nxt = S_RUN;
            else if ((TIMEOUT_CYC == 0) || (r_cnt == L_TO_LAST)) w_state_nxt = S_FAIL;
            else                                               w_state_nxt = S_WAIT;
         end
         S_RUN, S_FAIL: begin
            if (seq_start_i) w_state_nxt = L_START;
            else             w_state_nxt = r_state;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_cnt_nxt = '0;
      if ((w_state_nxt == r_state) && ((r_state == S_PRE) || (r_state == S_ASSERT) || (r_state == S_WAIT)))
         w_cnt_nxt = r_cnt + CNT_W'(1);
      else
         w_cnt_nxt = '0;
   end

   // Status decode from the next state so the registered outputs line up with the state.
   always_comb begin
      w_resetn_nxt = 1'b1;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      w_to_nxt     = 1'b0;
      case (w_state_nxt)
         S_PRE:    w_busy_nxt = 1'b1;
         S_ASSERT: begin
            w_busy_nxt   = 1'b1;
            w_resetn_nxt = 1'b0;
         end
         S_WAIT:   w_busy_nxt = 1'b1;
         S_RUN:    w_done_nxt = 1'b1;
         S_FAIL:   w_to_nxt   = 1'b1;
         default:  w_busy_nxt = 1'b0;
      endcase
   end

   assign sdram_resetn_o = r_resetn;
   assign seq_busy_o     = r_busy;
   assign seq_done_o     = r_done;
   assign seq_timeout_o  = r_to;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [7:0] L_DIV = DIV_HALF[8*gi +: 8];
      localparam logic [7:0] L_PH  = PHASE[8*gi +: 8];
      if (L_DIV == 8'd0) begin : g_off
         assign clk_div_o[gi] = 1'b0;
         assign ch_rise_o[gi] = 1'b0;
      end else begin : g_on
         logic [7:0] r_cnt_ch;
         logic       r_ph, r_clk, r_rise;
         logic       w_ph_done, w_hit;

         assign w_ph_done = r_ph | (L_PH == 8'd0);
         assign w_hit     = w_ph_done && (({1'b0, r_cnt_ch} + 9'd1) == {1'b0, L_DIV});

         // Count out the start delay once, then toggle every L_DIV cycles.
         always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
               r_cnt_ch <= 8'd0;
               r_ph     <= 1'b0;
               r_clk    <= 1'b0;
               r_rise   <= 1'b0;
            end else if (!w_ph_done) begin
               r_rise <= 1'b0;
               if (({1'b0, r_cnt_ch} + 9'd1) == {1'b0, L_PH}) begin
                  r_ph     <= 1'b1;
                  r_cnt_ch <= 8'd0;
               end else begin
                  r_cnt_ch <= r_cnt_ch + 8'd1;
               end
            end else if (w_hit) begin
               r_cnt_ch <= 8'd0;
               r_clk    <= ~r_clk;
               r_rise   <= ~r_clk;
            end else begin
               r_cnt_ch <= r_cnt_ch + 8'd1;
               r_rise   <= 1'b0;
            end
         end

         assign clk_div_o[gi] = r_clk;
         assign ch_rise_o[gi] = r_rise;
      end
   end

endmodule
